shift_sequencer: RTL and testbench

Multi-cycle controller for ARM register-specified shifts (Rm shifted by Rs[7:0]), performed in the operand-2 path.
- Accepts a value, a shift mode, an 8-bit amount and a carry-in over a valid/ready handshake.
- Reduces the amount to an effective count, then iterates a bounded shifter until done.
- Returns the shifted operand plus the shifter carry-out.
- Sits between the register-read/decode stage and the ALU operand-2 mux; the hazard unit stalls the pipe while it is busy.

---
 rtl/shift_sequencer_pkg.sv | 31 +++
 rtl/shift_sequencer_step.sv | 46 ++++
 rtl/shift_sequencer.sv | 119 +++++++++++
 tb/tb_shift_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the register-specified shift sequencer: mode codes,
// FSM states, clamp limits and the amount-to-effective-count reduction.
package shift_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [5:0] LIM_LSX = 6'd33;
  localparam logic [5:0] LIM_ASR = 6'd32;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // 33 for logical shifts guarantees a zero carry for any amount above 32.
  function automatic logic [5:0] eff_count(input logic [1:0] mode, input logic [7:0] amt);
    logic [5:0] r_cnt;
    r_cnt = '0;
    case (mode)
      SH_LSL, SH_LSR: r_cnt = (amt > {2'b00, LIM_LSX}) ? LIM_LSX : amt[5:0];
      SH_ASR:         r_cnt = (amt > {2'b00, LIM_ASR}) ? LIM_ASR : amt[5:0];
      default: begin
        if (amt == 8'd0)           r_cnt = 6'd0;
        else if (amt[4:0] == 5'd0) r_cnt = 6'd32;
        else                       r_cnt = {1'b0, amt[4:0]};
      end
    endcase
    return r_cnt;
  endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// Combinational bounded shifter: shifts/rotates by k (0..32) and reports the
// last bit moved out; k==0 passes value and carry through untouched.
module shift_step
  import shift_pkg::*;
(
  input  logic [31:0] i_value,
  input  logic [1:0]  i_mode,
  input  logic [5:0]  i_k,
  input  logic        i_carry,
  output logic [31:0] o_value,
  output logic        o_carry
);

  logic [5:0] w_lo_idx;
  logic [5:0] w_hi_idx;

  assign w_lo_idx = i_k - 6'd1;
  assign w_hi_idx = 6'd32 - i_k;

  always_comb begin
    o_value = i_value;
    o_carry = i_carry;
    if (i_k != 6'd0) begin
      case (i_mode)
        SH_LSL: begin
          o_value = i_value << i_k;
          o_carry = i_value[w_hi_idx[4:0]];
        end
        SH_LSR: begin
          o_value = i_value >> i_k;
          o_carry = i_value[w_lo_idx[4:0]];
        end
        SH_ASR: begin
          o_value = $unsigned($signed(i_value) >>> i_k);
          o_carry = i_value[w_lo_idx[4:0]];
        end
        default: begin
          // k==32 gives a left shift of 0, so the rotate returns the input.
          o_value = (i_value >> i_k) | (i_value << w_hi_idx);
          o_carry = i_value[w_lo_idx[4:0]];
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle ARM register-specified shift controller (valid/ready in and out).
// Define SHIFTSEQ_FLUSH_EN to add a flush port that abandons the op in flight.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [1:0]  in_mode,
  input  logic [7:0]  in_amount,
  input  logic        in_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_value,
  output logic        out_carry,
  output logic        busy
`ifdef SHIFTSEQ_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      r_state;
  logic [31:0] r_value;
  logic [1:0]  r_mode;
  logic        r_carry;
  logic [5:0]  r_rem;
  logic        r_out_valid;
  logic        r_busy;

  logic        w_flush;
  logic        w_accept;
  logic [5:0]  w_eff;
  logic [5:0]  w_k;
  logic [31:0] w_step_value;
  logic        w_step_carry;

`ifdef SHIFTSEQ_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign in_ready = !w_flush && ((r_state == IDLE) || (r_state == DONE && out_ready));
  assign w_accept = in_valid && in_ready;
  assign w_eff    = eff_count(in_mode, in_amount);
  assign w_k      = (r_rem > STEP_W) ? STEP_W : r_rem;

  shift_step u_step (
    .i_value (r_value),
    .i_mode  (r_mode),
    .i_k     (w_k),
    .i_carry (r_carry),
    .o_value (w_step_value),
    .o_carry (w_step_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_value     <= '0;
      r_mode      <= SH_LSL;
      r_carry     <= 1'b0;
      r_rem       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_accept) begin
      // Covers both IDLE and the back-to-back hand-off out of DONE.
      r_value <= in_value;
      r_mode  <= in_mode;
      r_carry <= in_carry;
      r_rem   <= w_eff;
      r_busy  <= 1'b1;
      if (w_eff == 6'd0) begin
        r_state     <= DONE;
        r_out_valid <= 1'b1;
      end else begin
        r_state     <= SHIFT;
        r_out_valid <= 1'b0;
      end
    end else begin
      case (r_state)
        SHIFT: begin
          r_value <= w_step_value;
          r_carry <= w_step_carry;
          r_rem   <= r_rem - w_k;
          if (r_rem == w_k) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_value = r_value;
  assign out_carry = r_carry;
  assign busy      = r_busy;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (STEP=8): ARM shift semantics, latency,
// back-pressure, back-to-back hand-off, reset and optional flush.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_value = '0;
  logic [1:0]  in_mode = 2'b00;
  logic [7:0]  in_amount = '0;
  logic        in_carry = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_value;
  logic        out_carry;
  logic        busy;
`ifdef SHIFTSEQ_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int pass_cnt = 0;
  int total = 0;

  shift_sequencer #(.STEP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_mode   (in_mode),
    .in_amount (in_amount),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_carry (out_carry),
    .busy      (busy)
`ifdef SHIFTSEQ_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single edge; caller ensures the DUT is idle.
  task automatic start_op(input logic [31:0] v, input logic [1:0] m,
                          input logic [7:0] a, input logic c);
    in_value = v; in_mode = m; in_amount = a; in_carry = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_value = 32'hDEADBEEF; in_amount = 8'hFF; in_carry = ~c;
  endtask

  // lat = 1 when out_valid is already up right after the accept edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total++; if (out_value !== 32'h0) $display("FAIL reset_out_value got %h exp 0", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b0) $display("FAIL reset_out_carry got %b exp 0", out_carry); else pass_cnt++;
    rst = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_lsl;
    int lat;
    start_op(32'h000000F1, 2'b00, 8'd4, 1'b0);
    wait_valid(lat);
    total++; if (out_value !== 32'h00000F10) $display("FAIL lsl4_value got %h exp 00000f10", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b0) $display("FAIL lsl4_carry got %b exp 0", out_carry); else pass_cnt++;
    total++; if (lat != 2) $display("FAIL lsl4_latency got %0d exp 2", lat); else pass_cnt++;
    release_out();
    start_op(32'h80000001, 2'b00, 8'd32, 1'b0);
    wait_valid(lat);
    total++; if (out_value !== 32'h0) $display("FAIL lsl32_value got %h exp 0", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b1) $display("FAIL lsl32_carry got %b exp 1", out_carry); else pass_cnt++;
    release_out();
  endtask

  task automatic test_lsr;
    int lat;
    start_op(32'h80000001, 2'b01, 8'd32, 1'b0);
    wait_valid(lat);
    total++; if (out_value !== 32'h0) $display("FAIL lsr32_value got %h exp 0", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b1) $display("FAIL lsr32_carry got %b exp 1", out_carry); else pass_cnt++;
    total++; if (lat != 5) $display("FAIL lsr32_latency got %0d exp 5", lat); else pass_cnt++;
    release_out();
    start_op(32'h80000001, 2'b01, 8'd200, 1'b1);
    wait_valid(lat);
    total++; if (out_value !== 32'h0) $display("FAIL lsr200_value got %h exp 0", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b0) $display("FAIL lsr200_carry got %b exp 0", out_carry); else pass_cnt++;
    total++; if (lat != 6) $display("FAIL lsr200_latency got %0d exp 6", lat); else pass_cnt++;
    release_out();
  endtask

  task automatic test_asr;
    int lat;
    start_op(32'h80000000, 2'b10, 8'd40, 1'b0);
    wait_valid(lat);
    total++; if (out_value !== 32'hFFFFFFFF) $display("FAIL asr40_value got %h exp ffffffff", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b1) $display("FAIL asr40_carry got %b exp 1", out_carry); else pass_cnt++;
    total++; if (lat != 5) $display("FAIL asr40_latency got %0d exp 5", lat); else pass_cnt++;
    release_out();
    start_op(32'h80000010, 2'b10, 8'd5, 1'b0);
    wait_valid(lat);
    total++; if (out_value !== 32'hFC000000) $display("FAIL asr5_value got %h exp fc000000", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b1) $display("FAIL asr5_carry got %b exp 1", out_carry); else pass_cnt++;
    release_out();
  endtask

  task automatic test_ror;
    int lat;
    start_op(32'h80000001, 2'b11, 8'd64, 1'b0);
    wait_valid(lat);
    total++; if (out_value !== 32'h80000001) $display("FAIL ror64_value got %h exp 80000001", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b1) $display("FAIL ror64_carry got %b exp 1", out_carry); else pass_cnt++;
    release_out();
    start_op(32'h12345678, 2'b11, 8'd0, 1'b1);
    wait_valid(lat);
    total++; if (out_value !== 32'h12345678) $display("FAIL ror0_value got %h exp 12345678", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b1) $display("FAIL ror0_carry got %b exp 1", out_carry); else pass_cnt++;
    total++; if (lat != 1) $display("FAIL ror0_latency got %0d exp 1", lat); else pass_cnt++;
    release_out();
    start_op(32'h80000001, 2'b11, 8'd36, 1'b1);
    wait_valid(lat);
    total++; if (out_value !== 32'h18000000) $display("FAIL ror36_value got %h exp 18000000", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b0) $display("FAIL ror36_carry got %b exp 0", out_carry); else pass_cnt++;
    release_out();
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(32'h00000001, 2'b00, 8'd1, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 3; i++) begin
      total++; if (out_value !== 32'h2 || out_valid !== 1'b1) $display("FAIL bp_hold%0d got %h/%b exp 00000002/1", i, out_value, out_valid); else pass_cnt++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d got %b exp 0", i, in_ready); else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    in_value = 32'h000000F0; in_mode = 2'b01; in_amount = 8'd4; in_carry = 1'b1;
    in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_accept_ready got %b exp 1", in_ready); else pass_cnt++;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL bp_new_shift got %b/%b exp 0/1", out_valid, busy); else pass_cnt++;
    wait_valid(lat);
    total++; if (out_value !== 32'h0000000F) $display("FAIL bp_new_value got %h exp 0000000f", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b0) $display("FAIL bp_new_carry got %b exp 0", out_carry); else pass_cnt++;
    total++; if (lat != 2) $display("FAIL bp_new_latency got %0d exp 2", lat); else pass_cnt++;
    release_out();
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(32'hA5A5A5A5, 2'b11, 8'd0, 1'b1);
    wait_valid(lat);
    out_ready = 1'b1;
    in_value = 32'h5A5A0000; in_mode = 2'b00; in_amount = 8'd0; in_carry = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid got %b exp 1", out_valid); else pass_cnt++;
    total++; if (out_value !== 32'h5A5A0000) $display("FAIL b2b_value got %h exp 5a5a0000", out_value); else pass_cnt++;
    total++; if (out_carry !== 1'b0) $display("FAIL b2b_carry got %b exp 0", out_carry); else pass_cnt++;
    release_out();
    total++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_rst_midshift;
    start_op(32'h80000001, 2'b01, 8'd200, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid got %b/%b exp 0/0", out_valid, busy); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b exp 1", in_ready); else pass_cnt++;
    rst = 1'b1;
    repeat (8) tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_stale got %b/%b exp 0/0", out_valid, busy); else pass_cnt++;
  endtask

`ifdef SHIFTSEQ_FLUSH_EN
  task automatic test_flush;
    start_op(32'h80000001, 2'b01, 8'd200, 1'b0);
    tick();
    flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b exp 0", in_ready); else pass_cnt++;
    tick();
    flush = 1'b0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL flush_mid got %b/%b exp 0/0", out_valid, busy); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL flush_ready_after got %b exp 1", in_ready); else pass_cnt++;
    repeat (8) tick();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_stale got %b exp 0", out_valid); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_lsl();
    test_lsr();
    test_asr();
    test_ror();
    test_backpressure();
    test_back_to_back();
    test_rst_midshift();
`ifdef SHIFTSEQ_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
